// File: rtl/mtra_controller.sv
// Control FSM for the multiplication-through-repeated-addition unit.
// Optional abort path is enabled by defining MTRA_ABORT_EN.
module mtra_controller #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          eqz,
    output logic          ldA,
    output logic          ldB,
    output logic          clrP,
    output logic          ldP,
    output logic          decB,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter_cnt
`ifdef MTRA_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ACCUM  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;
    logic   kill;

`ifdef MTRA_ABORT_EN
    assign kill = abort &&
                  (state == LOAD_A || state == LOAD_B || state == ACCUM);

    // Flag an abort during the IDLE cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) aborted <= 1'b0;
        else     aborted <= kill;
    end
`else
    assign kill = 1'b0;
`endif

    // Strobe decode from the state register; everything is held low in reset.
    always_comb begin
        in_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        clrP     = 1'b0;
        ldP      = 1'b0;
        decB     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: ;
                LOAD_A: begin
                    busy     = 1'b1;
                    in_ready = 1'b1;
                    ldA      = in_valid && !kill;
                end
                LOAD_B: begin
                    busy     = 1'b1;
                    in_ready = 1'b1;
                    ldB      = in_valid && !kill;
                    clrP     = in_valid && !kill;
                end
                ACCUM: begin
                    busy = 1'b1;
                    ldP  = !eqz && !kill;
                    decB = !eqz && !kill;
                end
                DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State sequencing and the iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_A;
                        iter_cnt <= '0;
                    end
                end
                LOAD_A: begin
                    if (kill)          state <= IDLE;
                    else if (in_valid) state <= LOAD_B;
                end
                LOAD_B: begin
                    if (kill)          state <= IDLE;
                    else if (in_valid) state <= ACCUM;
                end
                ACCUM: begin
                    if (kill)     state <= IDLE;
                    else if (eqz) state <= DONE;
                    else          iter_cnt <= iter_cnt + CW'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtra_controller.sv
// Bench for mtra_controller with a behavioural MTRA datapath beside it.
// Completions are checked by a scoreboard monitor against queued expectations.
module tb_mtra_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        eqz;
    logic        ldA, ldB, clrP, ldP, decB;
    logic        busy, done;
    logic [15:0] iter_cnt;
    logic [15:0] data_in;
    logic [15:0] op_data = '0;
    logic        auto_feed = 1'b0;
    logic        aborted_s;
`ifdef MTRA_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
    assign aborted_s = aborted;
`else
    assign aborted_s = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ldp_cnt = 0;

    typedef struct {
        logic [15:0] p;
        logic [15:0] it;
        int          at;
        int          ldp;
        bit          ab;
    } exp_t;
    exp_t q[$];

    // Behavioural datapath
    logic [15:0] reg_a = '0;
    logic [15:0] reg_b = '0;
    logic [15:0] reg_p = '0;
    assign eqz = (reg_b == 16'd0);
    assign data_in = auto_feed ? (ldA ? 16'd3 : 16'd1) : op_data;

    always @(posedge clk) begin
        if (ldA) reg_a <= data_in;
        if (ldB) reg_b <= data_in;
        else if (decB) reg_b <= reg_b - 16'd1;
        if (clrP) reg_p <= '0;
        else if (ldP) reg_p <= reg_p + reg_a;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mtra_controller #(.CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .eqz      (eqz),
        .ldA      (ldA),
        .ldB      (ldB),
        .clrP     (clrP),
        .ldP      (ldP),
        .decB     (decB),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
`ifdef MTRA_ABORT_EN
        ,
        .abort    (abort),
        .aborted  (aborted)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done or aborted pulse.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (clrP) ldp_cnt = 0;
            if (ldP) ldp_cnt++;
        end
        if (done || aborted_s) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_end", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("sb_kind_abort", 32'(aborted_s), 32'(e.ab));
                chk("sb_kind_done", 32'(done), 32'(!e.ab));
                chk("sb_cycle", 32'(cyc), 32'(e.at));
                chk("sb_iter_cnt", 32'(iter_cnt), 32'(e.it));
                chk("sb_ldp_pulses", 32'(ldp_cnt), 32'(e.ldp));
                if (!e.ab) chk("sb_product", 32'(reg_p), 32'(e.p));
            end
        end
    end

    task automatic push(input logic [15:0] p, input logic [15:0] it,
                        input int at, input int ldp, input bit ab);
        exp_t e;
        e.p = p; e.it = it; e.at = at; e.ldp = ldp; e.ab = ab;
        q.push_back(e);
    endtask

    // Issue a start and hand over A then B with optional stall cycles.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input int sa, input int sb, input bit do_push,
                            output int k);
        @(negedge clk);
        start = 1'b1;
        k = cyc;
        if (do_push) push(a * b, b, k + 4 + int'(b) + sa + sb, int'(b), 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (sa) begin
            in_valid = 1'b0;
            #1 chk("stall_a_ready", 32'(in_ready), 1);
            chk("stall_a_lda", 32'(ldA), 0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        op_data = a;
        #1 chk("lda", 32'(ldA), 1);
        chk("lda_cycle", 32'(cyc), 32'(k + 1 + sa));
        @(negedge clk);
        repeat (sb) begin
            in_valid = 1'b0;
            #1 chk("stall_b_ready", 32'(in_ready), 1);
            chk("stall_b_ldb", 32'(ldB), 0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        op_data = b;
        #1 chk("ldb", 32'(ldB), 1);
        chk("clrp", 32'(clrP), 1);
        chk("ldb_cycle", 32'(cyc), 32'(k + 2 + sa + sb));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        int k;
        // Reset behaviour
        @(negedge clk);
        #1 chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_iter", 32'(iter_cnt), 0);
        chk("rst_idle", 32'(busy), 0);

        // 5 x 3, no stalls: done at k+7
        start_op(16'd5, 16'd3, 0, 0, 1'b1, k);
        wait_idle();

        // 7 x 0: no additions, done at k+4
        start_op(16'd7, 16'd0, 0, 0, 1'b1, k);
        wait_idle();

        // 6 x 4 with 2 stall cycles on A and 1 on B
        start_op(16'd6, 16'd4, 2, 1, 1'b1, k);
        wait_idle();

        // Reset after 4 of 10 accumulations
        start_op(16'd9, 16'd10, 0, 0, 1'b0, k);
        #1 chk("accum_ldp", 32'(ldP), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_ldp", 32'(ldP), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_iter", 32'(iter_cnt), 0);
        chk("post_rst_done", 32'(done), 0);
        start_op(16'd2, 16'd2, 0, 0, 1'b1, k);
        wait_idle();

        // start held high, 3 x 1 back to back: one op every 6 cycles
        @(negedge clk);
        auto_feed = 1'b1;
        in_valid = 1'b1;
        start = 1'b1;
        k = cyc;
        push(16'd3, 16'd1, k + 5, 1, 1'b0);
        push(16'd3, 16'd1, k + 11, 1, 1'b0);
        push(16'd3, 16'd1, k + 17, 1, 1'b0);
        repeat (13) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        wait_idle();
        auto_feed = 1'b0;
        in_valid = 1'b0;

`ifdef MTRA_ABORT_EN
        // 4 x 6 aborted in the 3rd ACCUM cycle
        start_op(16'd4, 16'd6, 0, 0, 1'b0, k);
        push(16'd0, 16'd2, k + 6, 2, 1'b1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_ldp", 32'(ldP), 0);
        @(negedge clk);
        abort = 1'b0;
        #1 chk("abort_idle", 32'(busy), 0);
        repeat (4) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
